efuse_load_ctrl: RTL and testbench

//  Initiator side of the eFuse load handshake. Drives a level load request into the eFuse IP and

---
 rtl/efuse_pkg.sv | 25 ++
 rtl/efuse_load_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_efuse_load_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/efuse_pkg.sv
// ---------------------------------------------------------------------------
// efuse_pkg
// Shared types and constants for the eFuse load controller.
//   efuse_ld_st_e   : load sequencer states
//   EFUSE_RETRY_W   : width of the retry counter reported to software
//   EFUSE_DATA_NUM  : default number of fuse words
//   EFUSE_DW        : default bits per fuse word
//   EFUSE_IMG_W     : default width of the complete fuse image
// ---------------------------------------------------------------------------
package efuse_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        REL  = 3'd2,
        GAP  = 3'd3,
        ERR  = 3'd4
    } efuse_ld_st_e;

    localparam int EFUSE_RETRY_W  = 3;
    localparam int EFUSE_DATA_NUM = 8;
    localparam int EFUSE_DW       = 8;
    localparam int EFUSE_IMG_W    = EFUSE_DATA_NUM * EFUSE_DW;

endpackage : efuse_pkg

// File: rtl/efuse_load_ctrl.sv
// ---------------------------------------------------------------------------
// efuse_load_ctrl
// Initiator side of the eFuse load handshake. Raises a level request towards
// the eFuse IP, shadows the fuse image it returns and reports valid / busy /
// error status to the downstream trim logic. A load starts automatically
// after reset (AUTO_LOAD) and on every software reload pulse seen while idle.
// A request that is not answered within TIMEOUT_CYC cycles is retried up to
// MAX_RETRY times, with the request held low for a gap in between.
//
// Ports
//   i_clk              in   clock
//   i_rst_n            in   asynchronous active-low reset
//   i_reload_req       in   1-cycle pulse requesting a (re)load
//   o_efuse_load_req   out  registered level request to the eFuse IP
//   i_efuse_load_done  in   IP done, held high while the request is held
//   i_efuse_op_finish  in   IP operation finished, qualifies done
//   i_efuse_reg_update in   IP data strobe
//   i_efuse_reg_data   in   fuse image from the IP
//   o_efuse_data       out  shadowed fuse image
//   o_efuse_data_vld   out  shadow image valid
//   o_load_busy        out  load sequence in progress
//   o_load_err         out  sticky error: retries exhausted or release timeout
//   o_retry_cnt        out  retries used by the current load
// ---------------------------------------------------------------------------
module efuse_load_ctrl
    import efuse_pkg::*;
#(
    parameter int DATA_NUM    = EFUSE_DATA_NUM,
    parameter int DW          = EFUSE_DW,
    parameter int TIMEOUT_CYC = 256,
    parameter int MAX_RETRY   = 2,
    parameter bit AUTO_LOAD   = 1'b1
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_reload_req,
    output logic                       o_efuse_load_req,
    input  logic                       i_efuse_load_done,
    input  logic                       i_efuse_op_finish,
    input  logic                       i_efuse_reg_update,
    input  logic [DATA_NUM*DW-1:0]     i_efuse_reg_data,
    output logic [DATA_NUM*DW-1:0]     o_efuse_data,
    output logic                       o_efuse_data_vld,
    output logic                       o_load_busy,
    output logic                       o_load_err,
    output logic [EFUSE_RETRY_W-1:0]   o_retry_cnt
);

    localparam int TMR_W = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [TMR_W-1:0]         TMR_LAST  = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [TMR_W-1:0]         TMR_MAX   = '1;
    localparam logic [EFUSE_RETRY_W-1:0] RETRY_LIM = EFUSE_RETRY_W'(MAX_RETRY);

    efuse_ld_st_e               state_q, state_d;
    logic [TMR_W-1:0]           timer_q;
    logic                       timer_clr;
    logic [EFUSE_RETRY_W-1:0]   retry_q, retry_d;
    logic                       vld_q, vld_d;
    logic                       err_q, err_d;
    logic                       boot_q, boot_d;
    logic                       req_q;
    logic                       cap_en;
    logic                       done_ok;
    logic                       timer_last;

    // Done only counts once the IP also flags its operation as finished.
    assign done_ok    = i_efuse_load_done & i_efuse_op_finish;
    assign timer_last = (timer_q == TMR_LAST);

    // Next-state logic. The timer is shared by the REQ, GAP and REL waits and
    // is restarted on every entry into one of them. The boot flag makes the
    // first IDLE cycle after reset behave like a reload pulse.
    always_comb begin
        state_d   = state_q;
        retry_d   = retry_q;
        vld_d     = vld_q;
        err_d     = err_q;
        boot_d    = boot_q;
        timer_clr = 1'b0;
        cap_en    = 1'b0;
        case (state_q)
            IDLE: begin
                if (boot_q || i_reload_req) begin
                    state_d   = REQ;
                    boot_d    = 1'b0;
                    vld_d     = 1'b0;
                    err_d     = 1'b0;
                    retry_d   = '0;
                    timer_clr = 1'b1;
                end
            end
            REQ: begin
                cap_en = i_efuse_reg_update;
                if (done_ok) begin
                    state_d   = REL;
                    vld_d     = 1'b1;
                    timer_clr = 1'b1;
                end else if (timer_last) begin
                    timer_clr = 1'b1;
                    if (retry_q < RETRY_LIM) begin
                        retry_d = retry_q + EFUSE_RETRY_W'(1);
                        state_d = GAP;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ERR;
                    end
                end
            end
            GAP: begin
                // At least two low cycles, and the IP must have dropped done
                // from the previous attempt before the request rises again.
                if ((timer_q != '0) && !i_efuse_load_done) begin
                    state_d   = REQ;
                    timer_clr = 1'b1;
                end else if (timer_last) begin
                    err_d   = 1'b1;
                    state_d = ERR;
                end
            end
            REL: begin
                if (!i_efuse_load_done) begin
                    state_d = IDLE;
                end else if (timer_last) begin
                    err_d   = 1'b1;
                    vld_d   = 1'b0;
                    state_d = ERR;
                end
            end
            ERR: begin
                if (!i_efuse_load_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer state and status flags. The request is registered from the
    // next state so it rises and falls together with REQ and never glitches.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            retry_q <= '0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
            boot_q  <= AUTO_LOAD;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            retry_q <= retry_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
            boot_q  <= boot_d;
            req_q   <= (state_d == REQ);
        end
    end

    // Wait timer, saturating so a long stay in one state cannot wrap.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            timer_q <= '0;
        end else if (timer_clr) begin
            timer_q <= '0;
        end else if (timer_q != TMR_MAX) begin
            timer_q <= timer_q + TMR_W'(1);
        end
    end

    // Shadow image: every strobe while requesting overwrites, last one wins.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_efuse_data <= '0;
        end else if (cap_en) begin
            o_efuse_data <= i_efuse_reg_data;
        end
    end

    assign o_efuse_load_req = req_q;
    assign o_efuse_data_vld = vld_q;
    assign o_load_busy      = (state_q != IDLE);
    assign o_load_err       = err_q;
    assign o_retry_cnt      = retry_q;

endmodule : efuse_load_ctrl

// File: tb/tb_efuse_load_ctrl.sv
// ---------------------------------------------------------------------------
// tb_efuse_load_ctrl
// Bench for efuse_load_ctrl. dut_a (AUTO_LOAD=1, short timeout) talks to a
// configurable IP model (latency, muted attempts, missing finish, held done)
// and is followed cycle by cycle by a procedural timeline model. dut_b
// (AUTO_LOAD=0) sits on a fixed 1-cycle IP to show it stays quiet until asked.
// ---------------------------------------------------------------------------
module tb_efuse_load_ctrl;

    localparam int TMO       = 16;
    localparam int MAX_RETRY = 2;
    localparam int IMG_W     = 64;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // dut_a side
    logic             a_reload, a_req, a_done, a_fin, a_upd;
    logic [IMG_W-1:0] a_rdata, a_data;
    logic             a_vld, a_busy, a_err;
    logic [2:0]       a_retry;

    // dut_b side
    logic             b_reload, b_req, b_done, b_upd;
    logic [IMG_W-1:0] b_data;
    logic             b_vld, b_busy, b_err;
    logic [2:0]       b_retry;
    localparam logic [IMG_W-1:0] B_IMG = 64'h0123456789ABCDEF;

    efuse_load_ctrl #(
        .DATA_NUM(8), .DW(8), .TIMEOUT_CYC(TMO), .MAX_RETRY(MAX_RETRY), .AUTO_LOAD(1'b1)
    ) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_reload_req(a_reload),
        .o_efuse_load_req(a_req), .i_efuse_load_done(a_done),
        .i_efuse_op_finish(a_fin), .i_efuse_reg_update(a_upd),
        .i_efuse_reg_data(a_rdata), .o_efuse_data(a_data),
        .o_efuse_data_vld(a_vld), .o_load_busy(a_busy),
        .o_load_err(a_err), .o_retry_cnt(a_retry)
    );

    efuse_load_ctrl #(
        .DATA_NUM(8), .DW(8), .TIMEOUT_CYC(TMO), .MAX_RETRY(MAX_RETRY), .AUTO_LOAD(1'b0)
    ) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_reload_req(b_reload),
        .o_efuse_load_req(b_req), .i_efuse_load_done(b_done),
        .i_efuse_op_finish(b_done), .i_efuse_reg_update(b_upd),
        .i_efuse_reg_data(B_IMG), .o_efuse_data(b_data),
        .o_efuse_data_vld(b_vld), .o_load_busy(b_busy),
        .o_load_err(b_err), .o_retry_cnt(b_retry)
    );

    // Configurable IP for dut_a: answers after ip_lat cycles of request,
    // ignores attempts numbered below ip_mute_until, can suppress finish and
    // can keep done high after the request drops.
    int               ip_lat, ip_mute_until, ip_cnt;
    int               ip_att = 0;
    bit               ip_hold, ip_nofin;
    logic [IMG_W-1:0] ip_base, ip_data, tb_data;
    logic             ip_done, ip_upd, ip_prev_req, tb_upd;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ip_done <= 1'b0; ip_upd <= 1'b0; ip_cnt <= 0;
            ip_data <= '0;   ip_prev_req <= 1'b0;
        end else begin
            ip_upd <= 1'b0;
            if (a_req) begin
                if (ip_att >= ip_mute_until && !ip_done) begin
                    if (ip_cnt >= ip_lat - 1) begin
                        ip_done <= 1'b1;
                        ip_upd  <= 1'b1;
                        ip_data <= ip_base + 64'(ip_att);
                    end else begin
                        ip_cnt <= ip_cnt + 1;
                    end
                end
            end else begin
                ip_cnt <= 0;
                if (!ip_hold) ip_done <= 1'b0;
            end
            if (ip_prev_req && !a_req) ip_att <= ip_att + 1;
            ip_prev_req <= a_req;
        end
    end

    assign a_done  = ip_done;
    assign a_fin   = ip_done & ~ip_nofin;
    assign a_upd   = ip_upd | tb_upd;
    assign a_rdata = tb_upd ? tb_data : ip_data;

    // Fixed 1-cycle IP for dut_b
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_done <= 1'b0; b_upd <= 1'b0;
        end else begin
            b_done <= b_req;
            b_upd  <= b_req && !b_done;
        end
    end

    // Request activity counters
    int  a_req_cyc = 0, a_req_rise = 0, b_req_cyc = 0;
    logic a_req_prev = 1'b0;
    always @(negedge clk) begin
        if (a_req) begin
            a_req_cyc++;
            if (!a_req_prev) a_req_rise++;
        end
        a_req_prev = a_req;
        if (b_req) b_req_cyc++;
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input bit to_b, input bit val);
        @(negedge clk);
        if (to_b) b_reload = val;
        else      a_reload = val;
    endtask

    task automatic waitIdle(input int bound);
        int n = 0;
        while (a_busy && n < bound) begin
            @(negedge clk);
            n++;
        end
        checkOutput("wait_idle", 64'(a_busy), 64'd0);
    endtask

    // Timeline model of dut_a: a load is a run of request windows, each
    // either answered (then release wait) or timed out (then gap or error).
    logic             m_req, m_vld, m_err, m_busy;
    int               m_retry;
    logic [IMG_W-1:0] m_data;
    bit               m_ab, m_boot;

    task automatic step(output bit ab);
        @(posedge clk or negedge rst_n);
        ab = (rst_n == 1'b0);
    endtask

    task automatic runLoad(output bit ab);
        bit got;
        ab = 1'b0;
        m_req = 1'b1; m_busy = 1'b1; m_vld = 1'b0; m_err = 1'b0; m_retry = 0;
        forever begin
            got = 1'b0;
            for (int k = 0; k < TMO; k++) begin
                step(ab); if (ab) return;
                if (a_upd) m_data = a_rdata;
                if (a_done && a_fin) begin got = 1'b1; break; end
            end
            m_req = 1'b0;
            if (got) begin
                m_vld = 1'b1;
                for (int j = 0; j < TMO; j++) begin
                    step(ab); if (ab) return;
                    if (!a_done) begin m_busy = 1'b0; return; end
                end
                m_err = 1'b1; m_vld = 1'b0;
                break;
            end
            if (m_retry >= MAX_RETRY) begin m_err = 1'b1; break; end
            m_retry++;
            got = 1'b0;
            for (int g = 0; ; g++) begin
                step(ab); if (ab) return;
                if (g >= 1 && !a_done) break;
                if (g == TMO - 1) begin m_err = 1'b1; got = 1'b1; break; end
            end
            if (got) break;
            m_req = 1'b1;
        end
        forever begin
            step(ab); if (ab) return;
            if (!a_done) begin m_busy = 1'b0; return; end
        end
    endtask

    initial begin
        m_req = 0; m_vld = 0; m_err = 0; m_busy = 0; m_retry = 0; m_data = '0;
        forever begin
            wait (rst_n === 1'b1);
            m_boot = 1'b1;
            m_ab   = 1'b0;
            while (!m_ab) begin
                step(m_ab);
                if (!m_ab && (m_boot || a_reload)) begin
                    m_boot = 1'b0;
                    runLoad(m_ab);
                end
            end
            m_req = 0; m_vld = 0; m_err = 0; m_busy = 0; m_retry = 0; m_data = '0;
        end
    end

    // Cycle-by-cycle comparison of dut_a against the model
    always @(negedge clk) begin
        checkOutput("m_req",   64'(a_req),   64'(m_req));
        checkOutput("m_vld",   64'(a_vld),   64'(m_vld));
        checkOutput("m_busy",  64'(a_busy),  64'(m_busy));
        checkOutput("m_err",   64'(a_err),   64'(m_err));
        checkOutput("m_retry", 64'(a_retry), 64'(m_retry));
        checkOutput("m_data",  a_data,       m_data);
    end

    int r0, c0, b0, att0;

    initial begin
        $display("[TB] efuse_load_ctrl bench start");
        rst_n = 1'b1; a_reload = 0; b_reload = 0; tb_upd = 0; tb_data = '0;
        ip_lat = 1; ip_mute_until = 0; ip_hold = 0; ip_nofin = 0;
        ip_base = 64'hA5A5A5A5A5A5A5A5;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_req",  64'(a_req),  64'd0);
        checkOutput("rst_data", a_data,      64'd0);
        rst_n = 1'b1;

        // Boot load against a 1-cycle IP
        @(posedge clk); #1;
        checkOutput("boot_req_e0",  64'(a_req),  64'd1);
        checkOutput("boot_busy_e0", 64'(a_busy), 64'd1);
        @(posedge clk); #1;
        checkOutput("boot_req_e1",  64'(a_req),  64'd1);
        @(posedge clk); #1;
        checkOutput("boot_req_e2",  64'(a_req),  64'd0);
        checkOutput("boot_vld_e2",  64'(a_vld),  64'd1);
        checkOutput("boot_data_e2", a_data,      64'hA5A5A5A5A5A5A5A5);
        @(posedge clk); #1;
        checkOutput("boot_busy_e3", 64'(a_busy), 64'd1);
        @(posedge clk); #1;
        checkOutput("boot_busy_e4", 64'(a_busy), 64'd0);

        // No auto load on dut_b, then a reload pulse
        b0 = b_req_cyc;
        repeat (20) @(negedge clk);
        checkOutput("b_no_autoload", 64'(b_req_cyc - b0), 64'd0);
        checkOutput("b_idle_busy",   64'(b_busy),         64'd0);
        applyStimulus(1'b1, 1'b1);
        @(posedge clk); #1;
        checkOutput("b_req_next_edge", 64'(b_req), 64'd1);
        applyStimulus(1'b1, 1'b0);
        @(posedge clk); @(posedge clk); #1;
        checkOutput("b_vld_2_later", 64'(b_vld), 64'd1);
        checkOutput("b_data",        b_data,     B_IMG);
        checkOutput("b_err",         64'({b_err, b_retry}), 64'd0);

        // Strobe while idle must not touch the shadow image
        @(negedge clk); tb_data = 64'hDEADBEEFDEADBEEF; tb_upd = 1'b1;
        @(negedge clk); tb_upd = 1'b0;
        checkOutput("idle_strobe_ignored", a_data, 64'hA5A5A5A5A5A5A5A5);

        // Reload pulses during REQ and REL are dropped
        r0 = a_req_rise;
        applyStimulus(1'b0, 1'b1); applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1); applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1); applyStimulus(1'b0, 1'b0);
        repeat (10) @(negedge clk);
        checkOutput("reload_busy_dropped", 64'(a_req_rise - r0), 64'd1);
        checkOutput("reload_done_vld",     64'(a_vld),           64'd1);

        // IP never answers: three windows, then error
        ip_mute_until = 1000000;
        r0 = a_req_rise; c0 = a_req_cyc;
        applyStimulus(1'b0, 1'b1); applyStimulus(1'b0, 1'b0);
        waitIdle(200);
        checkOutput("tmo_windows",  64'(a_req_rise - r0), 64'd3);
        checkOutput("tmo_req_cyc",  64'(a_req_cyc - c0),  64'd48);
        checkOutput("tmo_retry",    64'(a_retry),         64'd2);
        checkOutput("tmo_err",      64'(a_err),           64'd1);
        checkOutput("tmo_vld",      64'(a_vld),           64'd0);

        // Reload after error clears it on start
        ip_mute_until = 0;
        applyStimulus(1'b0, 1'b1);
        @(posedge clk); #1;
        checkOutput("err_clr_on_start", 64'(a_err),  64'd0);
        checkOutput("busy_on_start",    64'(a_busy), 64'd1);
        applyStimulus(1'b0, 1'b0);
        waitIdle(50);
        checkOutput("recover_vld",   64'(a_vld),   64'd1);
        checkOutput("recover_retry", 64'(a_retry), 64'd0);

        // Answer on the second attempt only
        ip_base = 64'h1122334455667788;
        att0 = ip_att;
        ip_mute_until = att0 + 1;
        applyStimulus(1'b0, 1'b1); applyStimulus(1'b0, 1'b0);
        waitIdle(100);
        checkOutput("retry1_cnt",  64'(a_retry), 64'd1);
        checkOutput("retry1_err",  64'(a_err),   64'd0);
        checkOutput("retry1_vld",  64'(a_vld),   64'd1);
        checkOutput("retry1_data", a_data,       64'h1122334455667788 + 64'(att0 + 1));
        ip_mute_until = 0;

        // Done without finish never completes a load
        ip_nofin = 1'b1;
        applyStimulus(1'b0, 1'b1); applyStimulus(1'b0, 1'b0);
        waitIdle(300);
        checkOutput("nofin_err",   64'(a_err),   64'd1);
        checkOutput("nofin_retry", 64'(a_retry), 64'd2);
        ip_nofin = 1'b0;

        // IP keeps done high after the request drops: release timeout
        ip_hold = 1'b1;
        applyStimulus(1'b0, 1'b1); applyStimulus(1'b0, 1'b0);
        repeat (25) @(negedge clk);
        checkOutput("rel_tmo_busy", 64'(a_busy), 64'd1);
        checkOutput("rel_tmo_err",  64'(a_err),  64'd1);
        checkOutput("rel_tmo_vld",  64'(a_vld),  64'd0);
        ip_hold = 1'b0;
        waitIdle(20);
        checkOutput("rel_tmo_sticky", 64'(a_err), 64'd1);

        // Reset in the middle of a request
        ip_lat = 4;
        applyStimulus(1'b0, 1'b1); applyStimulus(1'b0, 1'b0);
        @(negedge clk);
        checkOutput("pre_rst_req", 64'(a_req), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_req",  64'(a_req),  64'd0);
        checkOutput("mid_rst_data", a_data,      64'd0);
        checkOutput("mid_rst_flags", 64'({a_vld, a_err, a_busy}), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("restart_req_e0", 64'(a_req), 64'd1);
        waitIdle(50);
        checkOutput("restart_vld", 64'(a_vld), 64'd1);
        checkOutput("restart_err", 64'(a_err), 64'd0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_efuse_load_ctrl
